npu_acc_seq: RTL and testbench
==============================

Name: npu_acc_seq

Overview:
- Sequencer for one MAC lane of the NPU datapath, built from 24-bit hold registers (s=0 load, s=1 hold).
- Drives the hold selects of the weight, input-sample and result registers.
- Drives clear/enable of the accumulator and tracks samples through a PIPE-deep multiply/add pipeline.
- Runs one dot-product job of `len` terms per `start`, with valid/ready handshakes on sample input and result output.

Parameters:
- LEN_W, 8, width of job length and term counter.
- PIPE, 2, multiply+add pipeline depth in cycles between sample acceptance and its accumulator write (legal range 1..8).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  job request; sampled only in IDLE.
- len  in  LEN_W  number of terms; latched when start is accepted.
- busy  out  1  high in every state except IDLE.
- x_valid  in  1  input sample valid.
- x_ready  out  1  sequencer accepts a sample this cycle.
- w_s  out  1  weight register hold select (0 = load).
- x_s  out  1  input sample register hold select (0 = load).
- acc_clr  out  1  accumulator clear pulse.
- acc_en  out  1  accumulator add enable.
- res_s  out  1  result register hold select (0 = capture).
- res_valid  out  1  result register holds a completed job.
- res_ready  in  1  downstream consumes the result.
- cnt  out  LEN_W  samples accepted in the current job.

Behaviour:
- Reset (asynchronous, any state, mid-job included):
  - State returns to IDLE.
  - w_s, x_s and res_s go to 1.
  - busy, x_ready, acc_clr, acc_en and res_valid go to 0; cnt goes to 0.
  - Pending-sample tracker is cleared.
- Default outputs in every state: all selects 1 (hold), all strobes 0.
- States: IDLE, WLOAD, ACC, DRAIN, CAPT, OUT.
- IDLE:
  - start=1: latch len, clear cnt, next state WLOAD.
  - start=0: stay in IDLE.
- WLOAD, exactly 1 cycle:
  - w_s=0 and acc_clr=1.
  - Next state CAPT if the latched len is 0, otherwise ACC.
- ACC:
  - x_ready=1.
  - On acceptance (x_valid&x_ready): x_s=0 in that cycle, cnt increments, and a token is pushed into a PIPE-stage shift tracker.
  - When the accepted sample is number len (cnt becomes len), next state DRAIN.
  - x_valid=0 stalls the state; no cnt change and no x_s pulse.
- acc_en, in all states:
  - acc_en=1 in cycle c exactly when a sample was accepted in cycle c-PIPE.
  - Stall bubbles therefore propagate as acc_en gaps.
- DRAIN:
  - x_ready=0.
  - Stays while tracker tokens remain.
  - In the cycle acc_en fires for the last token, next state CAPT.
- CAPT, exactly 1 cycle: res_s=0, next state OUT.
- OUT:
  - res_valid=1 and res_s=1.
  - Held indefinitely while res_ready=0.
  - On res_valid&res_ready, next state IDLE.
- start is ignored outside IDLE, with no queuing. A start asserted in the OUT handshake cycle is not accepted; it must still be high the following IDLE cycle.
- cnt keeps the final value through OUT and clears on the next job's acceptance.
- Counter width: cnt saturates logically at len. Max len = 2^LEN_W-1 = 255 with no wrap.
- Latency with x_valid held high, start accepted at cycle 0:
  - len>0: first res_valid at cycle len+PIPE+3.
  - len=0: first res_valid at cycle 3.

Test Plan:
- Reset mid-job: assert rst_n=0 during ACC with cnt=2 -> outputs return to reset values immediately. After release, start len=1 completes normally with no leftover acc_en.
- Nominal job, PIPE=2, len=3, start at cycle 0, x_valid=1:
  - w_s=0 and acc_clr=1 at cycle 1.
  - x_s=0 at cycles 2-4, acc_en at cycles 4-6.
  - res_s=0 at cycle 7, res_valid=1 from cycle 8; cnt=3.
- Stalls, len=3, x_valid pattern 1,0,0,1,1 from cycle 2:
  - Accepts at cycles 2, 5 and 6; acc_en at cycles 4, 7 and 8.
  - res_s=0 at cycle 9, res_valid from cycle 10.
- len=0: start at cycle 0 -> WLOAD at cycle 1, res_s=0 at cycle 2, res_valid at cycle 3. x_ready and acc_en never assert.
- Backpressure: res_ready=0 for 5 cycles in OUT -> res_valid stays 1 and res_s stays 1. A start pulse during OUT is ignored. Raising res_ready returns to IDLE the next cycle with busy=0.
- Max length: len=255, PIPE=8, continuous x_valid -> exactly 255 acc_en cycles, cnt=255, res_valid at cycle 266.

Source files
------------

// File: rtl/npu_acc_seq.sv
// Sequencer for one MAC lane: steers the weight/sample/result hold registers and
// the accumulator, and tracks accepted samples through the PIPE-deep multiply/add path.
module npu_acc_seq #(
  parameter int LEN_W = 8,
  parameter int PIPE  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             x_valid,
  output logic             x_ready,
  output logic             w_s,
  output logic             x_s,
  output logic             acc_clr,
  output logic             acc_en,
  output logic             res_s,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [LEN_W-1:0] cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WLOAD,
    S_ACC,
    S_DRAIN,
    S_CAPT,
    S_OUT
  } state_e;

  // Marks the tracker stage whose token is firing acc_en in the current cycle.
  localparam logic [PIPE-1:0] TOP_BIT = PIPE'(1) << (PIPE - 1);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [PIPE-1:0]  trk_q, trk_d;
  logic             accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      trk_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      trk_q   <= trk_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    busy      = 1'b1;
    x_ready   = 1'b0;
    w_s       = 1'b1;
    x_s       = 1'b1;
    acc_clr   = 1'b0;
    res_s     = 1'b1;
    res_valid = 1'b0;
    accept    = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          len_d   = len;
          cnt_d   = '0;
          state_d = S_WLOAD;
        end
      end
      S_WLOAD: begin
        w_s     = 1'b0;
        acc_clr = 1'b1;
        state_d = (len_q == '0) ? S_CAPT : S_ACC;
      end
      S_ACC: begin
        x_ready = 1'b1;
        if (x_valid) begin
          accept = 1'b1;
          x_s    = 1'b0;
          cnt_d  = cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Leave once the only remaining token is the one writing the accumulator now.
        if ((trk_q & ~TOP_BIT) == '0) state_d = S_CAPT;
      end
      S_CAPT: begin
        res_s   = 1'b0;
        state_d = S_OUT;
      end
      S_OUT: begin
        res_valid = 1'b1;
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    trk_d = (trk_q << 1) | PIPE'(accept);
  end

  assign acc_en = trk_q[PIPE-1];
  assign cnt    = cnt_q;

endmodule

// File: tb/tb_npu_acc_seq.sv
// Scoreboard bench for npu_acc_seq: a job-level timeline model predicts every strobe,
// and a negedge monitor pops and compares whenever the sequencer emits one.
module tb_npu_acc_seq;

  localparam int PIPE  = 2;
  localparam int LEN_W = 8;

  logic             clk;
  logic             rst_n, start, x_valid, res_ready;
  logic [LEN_W-1:0] len;
  logic             busy, x_ready, w_s, x_s, acc_clr, acc_en, res_s, res_valid;
  logic [LEN_W-1:0] cnt;

  logic             rst8_n, start8, x_valid8, res_ready8;
  logic [LEN_W-1:0] len8;
  logic             busy8, x_ready8, w_s8, x_s8, acc_clr8, acc_en8, res_s8, res_valid8;
  logic [LEN_W-1:0] cnt8;

  npu_acc_seq #(.LEN_W(LEN_W), .PIPE(PIPE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy),
    .x_valid(x_valid), .x_ready(x_ready), .w_s(w_s), .x_s(x_s),
    .acc_clr(acc_clr), .acc_en(acc_en), .res_s(res_s), .res_valid(res_valid),
    .res_ready(res_ready), .cnt(cnt)
  );

  npu_acc_seq #(.LEN_W(LEN_W), .PIPE(8)) dut8 (
    .clk(clk), .rst_n(rst8_n), .start(start8), .len(len8), .busy(busy8),
    .x_valid(x_valid8), .x_ready(x_ready8), .w_s(w_s8), .x_s(x_s8),
    .acc_clr(acc_clr8), .acc_en(acc_en8), .res_s(res_s8), .res_valid(res_valid8),
    .res_ready(res_ready8), .cnt(cnt8)
  );

  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;
  bit  mon_en;
  bit  exp_busy, exp_xrdy;
  bit  done8;
  int  t0;
  int  wq[$], aq[$], eq[$], cq[$], rcq[$], rnq[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    cmp({tag, "_w_s"}, int'(w_s), 1);
    cmp({tag, "_x_s"}, int'(x_s), 1);
    cmp({tag, "_res_s"}, int'(res_s), 1);
    cmp({tag, "_busy"}, int'(busy), 0);
    cmp({tag, "_x_ready"}, int'(x_ready), 0);
    cmp({tag, "_acc_clr"}, int'(acc_clr), 0);
    cmp({tag, "_acc_en"}, int'(acc_en), 0);
    cmp({tag, "_res_valid"}, int'(res_valid), 0);
    cmp({tag, "_cnt"}, int'(cnt), 0);
  endtask

  // One job, entered in an IDLE cycle. mode 0: random x_valid, 1: always 1, 2: pattern bits.
  // d = cycles res_ready stays low in OUT; poke drives spurious start pulses while busy.
  task automatic run_job(input int L, input int d, input bit poke, input int mode,
                         input logic [31:0] pat);
    int n, i, last, capt, js;
    bit xv;
    start = 1'b1; len = LEN_W'(L); x_valid = 1'($urandom); res_ready = 1'b0;
    exp_busy = 1'b0; exp_xrdy = 1'b0;
    js = cyc;
    tick();
    start = 1'b0; exp_busy = 1'b1; x_valid = 1'($urandom);
    wq.push_back(cyc);
    n = 0; i = 0; last = js + 1;
    while (n < L) begin
      tick();
      exp_xrdy = 1'b1;
      start = poke ? 1'($urandom) : 1'b0;
      len = LEN_W'($urandom);
      case (mode)
        1: xv = 1'b1;
        2: xv = pat[i % 32];
        default: xv = ($urandom_range(0, 3) != 0);
      endcase
      x_valid = xv;
      i++;
      if (xv) begin
        aq.push_back(cyc);
        eq.push_back(cyc + PIPE);
        n++;
        last = cyc;
      end
    end
    capt = (L == 0) ? js + 2 : last + PIPE + 1;
    cq.push_back(capt);
    rcq.push_back(capt + 1);
    rnq.push_back(L);
    tick();
    exp_xrdy = 1'b0;
    while (cyc < capt + 1 + d) begin
      x_valid = 1'($urandom);
      start = poke ? 1'($urandom) : 1'b0;
      len = LEN_W'($urandom);
      tick();
    end
    res_ready = 1'b1; start = poke;
    tick();
    res_ready = 1'b0; start = 1'b0; exp_busy = 1'b0;
  endtask

  initial begin : monitor
    bit rv_prev;
    rv_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        cmp("busy", int'(busy), int'(exp_busy));
        cmp("x_ready", int'(x_ready), int'(exp_xrdy));
        if (!exp_busy) cmp("res_valid_idle", int'(res_valid), 0);
        if (!w_s) begin
          cmp("wload_cycle", cyc, (wq.size() != 0) ? wq.pop_front() : -1);
          cmp("acc_clr_with_wload", int'(acc_clr), 1);
        end else if (acc_clr) cmp("acc_clr_stray", 1, 0);
        if (!x_s) cmp("accept_cycle", cyc, (aq.size() != 0) ? aq.pop_front() : -1);
        if (acc_en) cmp("acc_en_cycle", cyc, (eq.size() != 0) ? eq.pop_front() : -1);
        if (!res_s) cmp("capt_cycle", cyc, (cq.size() != 0) ? cq.pop_front() : -1);
        if (res_valid && !rv_prev) begin
          cmp("res_valid_cycle", cyc, (rcq.size() != 0) ? rcq.pop_front() : -1);
          cmp("res_cnt", int'(cnt), (rnq.size() != 0) ? rnq.pop_front() : -1);
        end
        rv_prev = res_valid;
      end else rv_prev = 1'b0;
    end
  end

  initial begin : maxlen
    int ens, rvc, s0;
    bit got;
    done8 = 1'b0; rst8_n = 1'b1; start8 = 1'b0; len8 = '0; x_valid8 = 1'b0; res_ready8 = 1'b0;
    #2 rst8_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst8_n = 1'b1;
    tick();
    start8 = 1'b1; len8 = 8'd255; x_valid8 = 1'b1; res_ready8 = 1'b1;
    s0 = cyc; ens = 0; rvc = -1; got = 1'b0;
    for (int k = 1; k <= 400 && !got; k++) begin
      tick();
      start8 = 1'b0;
      if (acc_en8) ens++;
      if (res_valid8) begin
        got = 1'b1;
        rvc = cyc - s0;
        cmp("max_cnt", int'(cnt8), 255);
      end
    end
    cmp("max_acc_en_count", ens, 255);
    cmp("max_latency", rvc, 255 + 8 + 3);
    done8 = 1'b1;
  end

  initial begin : stim
    rst_n = 1'b1; start = 1'b0; len = '0; x_valid = 1'b0; res_ready = 1'b0;
    mon_en = 1'b0; exp_busy = 1'b0; exp_xrdy = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("rst");
    rst_n = 1'b1;
    tick();
    // Abort a job after two accepted samples, while acc_en is active.
    start = 1'b1; len = 8'd5; x_valid = 1'b1; t0 = cyc;
    tick();
    start = 1'b0;
    repeat (3) tick();
    cmp("mid_cnt", int'(cnt), 2);
    cmp("mid_acc_en", int'(acc_en), 1);
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    x_valid = 1'b0;
    tick();
    rst_n = 1'b1; exp_busy = 1'b0; exp_xrdy = 1'b0; mon_en = 1'b1;
    run_job(1, 0, 1'b0, 1, 32'h0);
    run_job(3, 0, 1'b0, 1, 32'h0);
    run_job(3, 0, 1'b0, 2, 32'b11001);
    run_job(0, 0, 1'b0, 0, 32'h0);
    run_job(2, 5, 1'b1, 1, 32'h0);
    for (int j = 0; j < 30; j++)
      run_job(($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 12)),
              int'($urandom_range(0, 5)), 1'($urandom), 0, 32'h0);
    repeat (4) tick();
    for (int k = 0; k < 1000 && !done8; k++) tick();
    cmp("maxlen_done", int'(done8), 1);
    cmp("leftover_events", wq.size() + aq.size() + eq.size() + cq.size() + rcq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
